// File: rtl/sram_pkg.sv
// Shared types and sizing helpers for the banked SRAM controller.
package sram_pkg;

    localparam int unsigned SRAM_WORD_BYTES = 4;

    typedef struct packed {
        logic        rvalid;
        logic        err;
        logic [31:0] rdata;
    } sram_resp_t;

    // 33 bits so a window covering the whole 4 GB space cannot wrap to zero.
    function automatic logic [32:0] window_bytes(input int unsigned num_blocks,
                                                 input int unsigned log_block_words);
        return 33'(num_blocks) << (log_block_words + $clog2(SRAM_WORD_BYTES));
    endfunction

endpackage

// File: rtl/sram_1rw1r_macro.sv
// Behavioural stand-in for the sky130 1rw1r 32-bit macro: active-low selects, registered dout.
module sram_1rw1r_macro #(
    parameter int ADDR_W = 9
) (
    input  logic              clk,
    input  logic              csb0,
    input  logic              web0,
    input  logic [3:0]        wmask0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [31:0]       din0,
    output logic [31:0]       dout0,
    input  logic              csb1,
    input  logic [ADDR_W-1:0] addr1,
    output logic [31:0]       dout1
);

    logic [31:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (!csb0) begin
            if (!web0) begin
                for (int i = 0; i < 4; i++) begin
                    if (wmask0[i]) mem[addr0][8*i +: 8] <= din0[8*i +: 8];
                end
            end else begin
                dout0 <= mem[addr0];
            end
        end
        if (!csb1) dout1 <= mem[addr1];
    end

endmodule

// File: rtl/sram_port_resp.sv
// Per-port response path: registers the granted access and steers macro dout back to the port.
// SRAM_OUT_REG_EN adds an output register stage (latency 2 instead of 1).
module sram_port_resp
    import sram_pkg::*;
#(
    parameter int NUM_BLOCKS = 24,
    parameter int BLK_W      = $clog2(NUM_BLOCKS)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         gnt,
    input  logic                         legal,
    input  logic                         we,
    input  logic [BLK_W-1:0]             blk,
    input  logic [NUM_BLOCKS-1:0][31:0]  dout,
    output sram_resp_t                   resp
);

    logic             gnt_q;
    logic             legal_q;
    logic             we_q;
    logic [BLK_W-1:0] blk_q;
    sram_resp_t       resp_c;

    always_ff @(posedge clk) begin
        if (rst) begin
            gnt_q   <= 1'b0;
            legal_q <= 1'b0;
            we_q    <= 1'b0;
            blk_q   <= '0;
        end else begin
            gnt_q   <= gnt;
            legal_q <= legal;
            we_q    <= we;
            if (gnt && legal) blk_q <= blk;
        end
    end

    // Only legal reads return macro data; writes and errors return zero.
    always_comb begin
        resp_c        = '0;
        resp_c.rvalid = gnt_q;
        resp_c.err    = gnt_q & ~legal_q;
        if (gnt_q && legal_q && !we_q) resp_c.rdata = dout[blk_q];
    end

`ifdef SRAM_OUT_REG_EN
    sram_resp_t resp_q;

    always_ff @(posedge clk) begin
        if (rst) resp_q <= '0;
        else     resp_q <= resp_c;
    end

    assign resp = resp_q;
`else
    assign resp = resp_c;
`endif

endmodule

// File: rtl/sram_banked_ctrl.sv
// Banked SRAM controller: window decode, d/i collision arbitration, error responses, illegal capture.
// Optional SRAM_OUT_REG_EN adds an output register stage on both response paths.
module sram_banked_ctrl
    import sram_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR       = 32'h8000_0000,
    parameter int          NUM_BLOCKS      = 24,
    parameter int          LOG_BLOCK_WORDS = 9,
    parameter int          BLK_W           = $clog2(NUM_BLOCKS)
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        d_req_i,
    output logic        d_gnt_o,
    input  logic [31:0] d_addr_i,
    input  logic        d_we_i,
    input  logic [3:0]  d_be_i,
    input  logic [31:0] d_wdata_i,
    output logic        d_rvalid_o,
    output logic        d_err_o,
    output logic [31:0] d_rdata_o,
    input  logic        i_req_i,
    output logic        i_gnt_o,
    input  logic [31:0] i_addr_i,
    output logic        i_rvalid_o,
    output logic        i_err_o,
    output logic [31:0] i_rdata_o,
    output logic        illegal_memory_o,
    output logic [31:0] illegal_addr_o,
    input  logic        illegal_clr_i,
    output logic [15:0] collision_cnt_o
);

    localparam int          SHIFT = LOG_BLOCK_WORDS + $clog2(SRAM_WORD_BYTES);
    localparam logic [32:0] WIN   = window_bytes(NUM_BLOCKS, LOG_BLOCK_WORDS);

    logic [31:0] d_off, i_off, d_blk_full, i_blk_full;
    logic        d_legal, i_legal, collision, d_ill, i_ill;
    logic [LOG_BLOCK_WORDS-1:0] d_word, i_word;
    logic [NUM_BLOCKS-1:0]        d_cs, i_cs;
    logic [NUM_BLOCKS-1:0][31:0]  dout0, dout1;
    sram_resp_t d_resp, i_resp;
    logic        unused;

    assign d_off      = d_addr_i - BASE_ADDR;
    assign i_off      = i_addr_i - BASE_ADDR;
    assign d_legal    = (d_addr_i >= BASE_ADDR) && ({1'b0, d_off} < WIN);
    assign i_legal    = (i_addr_i >= BASE_ADDR) && ({1'b0, i_off} < WIN);
    assign d_blk_full = d_off >> SHIFT;
    assign i_blk_full = i_off >> SHIFT;
    assign d_word     = d_off[SHIFT-1:2];
    assign i_word     = i_off[SHIFT-1:2];
    assign unused     = ^{d_off[1:0], i_off[1:0]};

    assign collision = d_req_i && d_we_i && i_req_i && d_legal && i_legal &&
                       (d_blk_full == i_blk_full) && (d_word == i_word);
    assign d_gnt_o   = d_req_i;
    assign i_gnt_o   = i_req_i && !collision;
    assign d_ill     = d_req_i && !d_legal;
    assign i_ill     = i_gnt_o && !i_legal;

    for (genvar b = 0; b < NUM_BLOCKS; b++) begin : g_blk
        assign d_cs[b] = d_req_i && d_legal && (d_blk_full == 32'(b));
        assign i_cs[b] = i_gnt_o && i_legal && (i_blk_full == 32'(b));

        sram_1rw1r_macro #(.ADDR_W(LOG_BLOCK_WORDS)) u_macro (
            .clk    (clk_i),
            .csb0   (~d_cs[b]),
            .web0   (~d_we_i),
            .wmask0 (d_be_i),
            .addr0  (d_word),
            .din0   (d_wdata_i),
            .dout0  (dout0[b]),
            .csb1   (~i_cs[b]),
            .addr1  (i_word),
            .dout1  (dout1[b])
        );
    end

    sram_port_resp #(.NUM_BLOCKS(NUM_BLOCKS), .BLK_W(BLK_W)) u_d_resp (
        .clk   (clk_i),
        .rst   (rst_i),
        .gnt   (d_gnt_o),
        .legal (d_legal),
        .we    (d_we_i),
        .blk   (d_blk_full[BLK_W-1:0]),
        .dout  (dout0),
        .resp  (d_resp)
    );

    sram_port_resp #(.NUM_BLOCKS(NUM_BLOCKS), .BLK_W(BLK_W)) u_i_resp (
        .clk   (clk_i),
        .rst   (rst_i),
        .gnt   (i_gnt_o),
        .legal (i_legal),
        .we    (1'b0),
        .blk   (i_blk_full[BLK_W-1:0]),
        .dout  (dout1),
        .resp  (i_resp)
    );

    assign d_rvalid_o = d_resp.rvalid;
    assign d_err_o    = d_resp.err;
    assign d_rdata_o  = d_resp.rdata;
    assign i_rvalid_o = i_resp.rvalid;
    assign i_err_o    = i_resp.err;
    assign i_rdata_o  = i_resp.rdata;

    // A new illegal access outranks a same-cycle clear; d beats i on capture.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            illegal_memory_o <= 1'b0;
            illegal_addr_o   <= '0;
            collision_cnt_o  <= '0;
        end else begin
            if (d_ill || i_ill) begin
                illegal_memory_o <= 1'b1;
                if (!illegal_memory_o || illegal_clr_i)
                    illegal_addr_o <= d_ill ? d_addr_i : i_addr_i;
            end else if (illegal_clr_i) begin
                illegal_memory_o <= 1'b0;
                illegal_addr_o   <= '0;
            end
            if (collision && collision_cnt_o != 16'hFFFF)
                collision_cnt_o <= collision_cnt_o + 16'd1;
        end
    end

endmodule

// File: tb/tb_sram_banked_ctrl.sv
// Directed self-checking bench for sram_banked_ctrl (default parameters, either latency build).
module tb_sram_banked_ctrl;

`ifdef SRAM_OUT_REG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        d_req_i, d_gnt_o, d_we_i;
    logic [31:0] d_addr_i, d_wdata_i, d_rdata_o;
    logic [3:0]  d_be_i;
    logic        d_rvalid_o, d_err_o;
    logic        i_req_i, i_gnt_o, i_rvalid_o, i_err_o;
    logic [31:0] i_addr_i, i_rdata_o;
    logic        illegal_memory_o, illegal_clr_i;
    logic [31:0] illegal_addr_o;
    logic [15:0] collision_cnt_o;

    int checks   = 0;
    int failures = 0;

    always #5 clk_i = ~clk_i;

    sram_banked_ctrl dut (
        .clk_i            (clk_i),
        .rst_i            (rst_i),
        .d_req_i          (d_req_i),
        .d_gnt_o          (d_gnt_o),
        .d_addr_i         (d_addr_i),
        .d_we_i           (d_we_i),
        .d_be_i           (d_be_i),
        .d_wdata_i        (d_wdata_i),
        .d_rvalid_o       (d_rvalid_o),
        .d_err_o          (d_err_o),
        .d_rdata_o        (d_rdata_o),
        .i_req_i          (i_req_i),
        .i_gnt_o          (i_gnt_o),
        .i_addr_i         (i_addr_i),
        .i_rvalid_o       (i_rvalid_o),
        .i_err_o          (i_err_o),
        .i_rdata_o        (i_rdata_o),
        .illegal_memory_o (illegal_memory_o),
        .illegal_addr_o   (illegal_addr_o),
        .illegal_clr_i    (illegal_clr_i),
        .collision_cnt_o  (collision_cnt_o)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle();
        d_req_i = 0; d_we_i = 0; d_be_i = 0; d_addr_i = 0; d_wdata_i = 0;
        i_req_i = 0; i_addr_i = 0; illegal_clr_i = 0;
    endtask

    task automatic d_drive(input logic [31:0] a, input logic we, input logic [3:0] be,
                           input logic [31:0] wd);
        d_req_i = 1; d_addr_i = a; d_we_i = we; d_be_i = be; d_wdata_i = wd;
    endtask

    task automatic i_drive(input logic [31:0] a);
        i_req_i = 1; i_addr_i = a;
    endtask

    // Clock the grant edge, go idle, and confirm rvalid rises exactly LAT edges later.
    task automatic finish_resp(input bit on_d, input bit on_i);
        for (int k = 1; k <= LAT; k++) begin
            step();
            if (k == 1) idle();
            if (on_d) check_eq("d_latency", 32'(d_rvalid_o), 32'(k == LAT));
            if (on_i) check_eq("i_latency", 32'(i_rvalid_o), 32'(k == LAT));
        end
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_d_rvalid"}, 32'(d_rvalid_o), 0);
        check_eq({tag, "_d_err"},    32'(d_err_o), 0);
        check_eq({tag, "_d_rdata"},  d_rdata_o, 0);
        check_eq({tag, "_i_rvalid"}, 32'(i_rvalid_o), 0);
        check_eq({tag, "_i_err"},    32'(i_err_o), 0);
        check_eq({tag, "_i_rdata"},  i_rdata_o, 0);
        check_eq({tag, "_ill_flag"}, 32'(illegal_memory_o), 0);
        check_eq({tag, "_ill_addr"}, illegal_addr_o, 0);
        check_eq({tag, "_coll_cnt"}, 32'(collision_cnt_o), 0);
    endtask

    initial begin
        idle();
        rst_i = 1;
        repeat (3) step();
        check_all_zero("reset");
        rst_i = 0;
        step();

        // Full write, then simultaneous d and i reads of the same word
        d_drive(32'h8000_0010, 1, 4'hF, 32'hA5A5_1234);
        #1 check_eq("wr_d_gnt", 32'(d_gnt_o), 1);
        finish_resp(1, 0);
        check_eq("wr_rdata_zero", d_rdata_o, 0);
        check_eq("wr_err", 32'(d_err_o), 0);
        d_drive(32'h8000_0010, 0, 4'h0, 32'h0);
        i_drive(32'h8000_0010);
        #1 check_eq("rd_i_gnt", 32'(i_gnt_o), 1);
        finish_resp(1, 1);
        check_eq("rd_d_data", d_rdata_o, 32'hA5A5_1234);
        check_eq("rd_d_err", 32'(d_err_o), 0);
        check_eq("rd_i_data", i_rdata_o, 32'hA5A5_1234);
        check_eq("rd_i_err", 32'(i_err_o), 0);

        // Partial byte-enable write over all-ones
        d_drive(32'h8000_0020, 1, 4'hF, 32'hFFFF_FFFF);
        finish_resp(1, 0);
        d_drive(32'h8000_0020, 1, 4'b0010, 32'h0000_7700);
        finish_resp(1, 0);
        d_drive(32'h8000_0020, 0, 4'h0, 32'h0);
        finish_resp(1, 0);
        check_eq("partial_wr", d_rdata_o, 32'hFFFF_77FF);

        // Last word of the window is legal
        i_drive(32'h8000_BFFC);
        finish_resp(0, 1);
        check_eq("top_word_err", 32'(i_err_o), 0);

        // Same-word write/read collision: i stalls one cycle, then sees new data
        d_drive(32'h8000_0200, 1, 4'hF, 32'h1357_9BDF);
        i_drive(32'h8000_0200);
        #1;
        check_eq("coll_d_gnt", 32'(d_gnt_o), 1);
        check_eq("coll_i_gnt", 32'(i_gnt_o), 0);
        step();
        d_req_i = 0; d_we_i = 0;
        #1;
        check_eq("coll_i_rvalid_stalled", 32'(i_rvalid_o), 0);
        check_eq("coll_i_regnt", 32'(i_gnt_o), 1);
        check_eq("coll_cnt", 32'(collision_cnt_o), 1);
        finish_resp(0, 1);
        check_eq("coll_i_data", i_rdata_o, 32'h1357_9BDF);

        // Illegal d read past the window end
        d_drive(32'h8000_C000, 0, 4'h0, 32'h0);
        finish_resp(1, 0);
        check_eq("ill_d_err", 32'(d_err_o), 1);
        check_eq("ill_d_rdata", d_rdata_o, 0);
        check_eq("ill_flag", 32'(illegal_memory_o), 1);
        check_eq("ill_addr", illegal_addr_o, 32'h8000_C000);

        // Illegal i read below the base leaves the captured address
        i_drive(32'h7FFF_FFFC);
        #1 check_eq("ill_i_gnt", 32'(i_gnt_o), 1);
        finish_resp(0, 1);
        check_eq("ill_i_err", 32'(i_err_o), 1);
        check_eq("ill_i_rdata", i_rdata_o, 0);
        check_eq("ill_addr_kept", illegal_addr_o, 32'h8000_C000);

        // Clear coinciding with a new illegal access: new access wins
        d_drive(32'h9000_0000, 0, 4'h0, 32'h0);
        illegal_clr_i = 1;
        finish_resp(1, 0);
        check_eq("clr_race_flag", 32'(illegal_memory_o), 1);
        check_eq("clr_race_addr", illegal_addr_o, 32'h9000_0000);

        // Plain clear
        illegal_clr_i = 1;
        step();
        illegal_clr_i = 0;
        check_eq("clr_flag", 32'(illegal_memory_o), 0);
        check_eq("clr_addr", illegal_addr_o, 0);

        // Both ports illegal in one cycle: d address captured
        d_drive(32'h8000_C004, 0, 4'h0, 32'h0);
        i_drive(32'h7000_0000);
        finish_resp(1, 1);
        check_eq("both_ill_addr", illegal_addr_o, 32'h8000_C004);
        check_eq("both_ill_i_err", 32'(i_err_o), 1);

        // Reset the cycle after a grant drops the pending response
        d_drive(32'h8000_0010, 0, 4'h0, 32'h0);
        i_drive(32'h8000_0010);
        step();
        idle();
        rst_i = 1;
        step();
        check_all_zero("rst_mid");
        rst_i = 0;
        repeat (3) begin
            step();
            check_eq("post_rst_d_rvalid", 32'(d_rvalid_o), 0);
            check_eq("post_rst_i_rvalid", 32'(i_rvalid_o), 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
